// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock.
// Each digit is shown for SCAN_DIV cycles, then all outputs are off for one cycle. Supports leading-zero blanking and per-field blinking.
module clock_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int SCAN_W    = 16,
  parameter int BLINK_DIV = 50,
  parameter int BLINK_W   = 8
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic [3:0] HourH,
  input  logic [3:0] HourL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic       blank_lz,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scanState_t;

  scanState_t          stateR, stateS;
  logic [2:0]          idxR, idxS, nextIdxS;
  logic [SCAN_W-1:0]   prescR, prescS;
  logic [BLINK_W-1:0]  frameR, frameS, nextFrameS;
  logic                phaseR, phaseS, nextPhaseS;
  logic [6:0]          segS, shownSegS;
  logic                dpS, shownDpS;
  logic [5:0]          anS;
  logic [3:0]          digitS;
  logic [1:0]          fieldS;
  logic                blinkS, lzS;

  function automatic logic [6:0] decodeBcd(input logic [3:0] v);
    case (v)
      4'd0:    decodeBcd = 7'b1111110;
      4'd1:    decodeBcd = 7'b0110000;
      4'd2:    decodeBcd = 7'b1101101;
      4'd3:    decodeBcd = 7'b1111001;
      4'd4:    decodeBcd = 7'b0110011;
      4'd5:    decodeBcd = 7'b1011011;
      4'd6:    decodeBcd = 7'b1011111;
      4'd7:    decodeBcd = 7'b1110000;
      4'd8:    decodeBcd = 7'b1111111;
      4'd9:    decodeBcd = 7'b1111011;
      default: decodeBcd = 7'b0000001;
    endcase
  endfunction

  // Next digit index and blink frame bookkeeping at the 5->0 wrap
  always_comb begin
    nextIdxS   = idxR + 3'd1;
    nextFrameS = frameR;
    nextPhaseS = phaseR;
    if (idxR == 3'd5) begin
      nextIdxS = 3'd0;
      if (frameR == BLINK_W'(BLINK_DIV - 1)) begin
        nextFrameS = '0;
        nextPhaseS = ~phaseR;
      end else begin
        nextFrameS = frameR + BLINK_W'(1);
      end
    end else begin
      nextIdxS = idxR + 3'd1;
    end
  end

  // Select the upcoming digit and the field it belongs to
  always_comb begin
    digitS = SecL;
    fieldS = 2'd3;
    case (nextIdxS)
      3'd0:    begin digitS = HourH; fieldS = 2'd1; end
      3'd1:    begin digitS = HourL; fieldS = 2'd1; end
      3'd2:    begin digitS = MinH;  fieldS = 2'd2; end
      3'd3:    begin digitS = MinL;  fieldS = 2'd2; end
      3'd4:    begin digitS = SecH;  fieldS = 2'd3; end
      3'd5:    begin digitS = SecL;  fieldS = 2'd3; end
      default: begin digitS = 4'd15; fieldS = 2'd0; end
    endcase
  end

  // Segment/dot value for the window about to open; blink wins over zero blanking
  always_comb begin
    blinkS = nextPhaseS && (blink_sel == fieldS);
    lzS    = (nextIdxS == 3'd0) && blank_lz && (HourH == 4'd0);
    if (blinkS || lzS) begin
      shownSegS = 7'b0000000;
    end else begin
      shownSegS = decodeBcd(digitS);
    end
    shownDpS = !blinkS && ((nextIdxS == 3'd1) || (nextIdxS == 3'd3));
  end

  // Scan FSM next-state and output values
  always_comb begin
    stateS = stateR;
    idxS   = idxR;
    prescS = prescR;
    frameS = frameR;
    phaseS = phaseR;
    segS   = seg;
    dpS    = dp;
    anS    = an;
    case (stateR)
      BLANK: begin
        stateS = SHOW;
        idxS   = nextIdxS;
        prescS = '0;
        frameS = nextFrameS;
        phaseS = nextPhaseS;
        anS    = ~(6'b000001 << nextIdxS);
        segS   = shownSegS;
        dpS    = shownDpS;
      end
      SHOW: begin
        if (prescR == SCAN_W'(SCAN_DIV - 1)) begin
          stateS = BLANK;
          anS    = 6'b111111;
          segS   = 7'b0000000;
          dpS    = 1'b0;
        end else begin
          prescS = prescR + SCAN_W'(1);
        end
      end
      default: begin
        stateS = BLANK;
        anS    = 6'b111111;
        segS   = 7'b0000000;
        dpS    = 1'b0;
      end
    endcase
  end

  // State and output registers, updated on the falling clock edge
  always_ff @(negedge CP or negedge nCR) begin
    if (!nCR) begin
      stateR <= BLANK;
      idxR   <= 3'd5;
      prescR <= '0;
      frameR <= '0;
      phaseR <= 1'b0;
      seg    <= 7'b0000000;
      dp     <= 1'b0;
      an     <= 6'b111111;
    end else begin
      stateR <= stateS;
      idxR   <= idxS;
      prescR <= prescS;
      frameR <= frameS;
      phaseR <= phaseS;
      seg    <= segS;
      dp     <= dpS;
      an     <= anS;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized self-checking bench for clock_display_scan against a timeline model
// derived from cycle number, digit period and frame count.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int SW = 4;
  localparam int BD = 2;
  localparam int BW = 2;

  logic       CP = 1'b0;
  logic       nCR = 1'b1;
  logic [3:0] HourH, HourL, MinH, MinL, SecH, SecL;
  logic       blank_lz;
  logic [1:0] blink_sel;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int checks = 0;
  int failures = 0;

  int         n;
  logic [6:0] expSeg;
  logic       expDp;
  logic [5:0] expAn;
  logic [6:0] segTable [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                                7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

  clock_display_scan #(.SCAN_DIV(SD), .SCAN_W(SW), .BLINK_DIV(BD), .BLINK_W(BW)) dut (
    .CP(CP), .nCR(nCR), .HourH(HourH), .HourL(HourL), .MinH(MinH), .MinL(MinL),
    .SecH(SecH), .SecL(SecL), .blank_lz(blank_lz), .blink_sel(blink_sel),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 CP = ~CP;

  function automatic logic [3:0] digitAt(int d);
    case (d)
      0: return HourH;
      1: return HourL;
      2: return MinH;
      3: return MinL;
      4: return SecH;
      default: return SecL;
    endcase
  endfunction

  task automatic setTime(input logic [3:0] hh, hl, mh, ml, sh, sl);
    HourH = hh; HourL = hl; MinH = mh; MinL = ml; SecH = sh; SecL = sl;
  endtask

  task automatic modelReset();
    n = 0;
    expAn = 6'b111111;
    expSeg = 7'b0000000;
    expDp = 1'b0;
  endtask

  // Predict outputs after the coming falling edge from the current inputs
  task automatic modelEdge();
    int p, d, f, ph;
    logic bl;
    n++;
    p = (n - 1) % (SD + 1);
    d = ((n - 1) / (SD + 1)) % 6;
    f = (n - 1) / (6 * (SD + 1));
    if (p == 0) begin
      ph = ((f + 1) / BD) % 2;
      bl = (ph == 1) && (int'(blink_sel) == d / 2 + 1);
      expAn = 6'b111111;
      expAn[d] = 1'b0;
      if (bl) expSeg = 7'b0000000;
      else if (d == 0 && blank_lz && HourH == 4'd0) expSeg = 7'b0000000;
      else expSeg = segTable[digitAt(d)];
      expDp = !bl && (d == 1 || d == 3);
    end else if (p == SD) begin
      expAn = 6'b111111;
      expSeg = 7'b0000000;
      expDp = 1'b0;
    end
  endtask

  task automatic startRun();
    nCR = 1'b0;
    repeat (2) @(posedge CP);
    nCR = 1'b1;
    modelReset();
    modelEdge();
  endtask

  task automatic test_reset();
    setTime(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    blank_lz = 1'b0;
    blink_sel = 2'd0;
    #2 nCR = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'b0000000, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b exp an=111111 seg=0000000 dp=0", an, seg, dp);
    end
    repeat (3) @(posedge CP);
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'b0000000, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold got an=%b seg=%b dp=%b exp an=111111 seg=0000000 dp=0", an, seg, dp);
    end
  endtask

  task automatic test_scan();
    setTime(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    blank_lz = 1'b0;
    blink_sel = 2'd0;
    startRun();
    for (int c = 0; c < 65; c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL scan n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      modelEdge();
    end
  endtask

  task automatic test_dash();
    setTime(4'd1, 4'hC, 4'd3, 4'd4, 4'd5, 4'd6);
    startRun();
    for (int c = 0; c < 32; c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL dash n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      modelEdge();
    end
  endtask

  task automatic test_lz();
    setTime(4'd0, 4'd7, 4'd0, 4'd9, 4'd0, 4'd8);
    blank_lz = 1'b1;
    startRun();
    for (int c = 0; c < 70; c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL lz n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      if (c == 33) HourH = 4'd1;
      modelEdge();
    end
  endtask

  task automatic test_blink();
    setTime(4'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'd1);
    blank_lz = 1'b0;
    blink_sel = 2'd2;
    startRun();
    for (int c = 0; c < 8 * 6 * (SD + 1); c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL blink n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      modelEdge();
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      blink_sel = 2'($urandom_range(0, 3));
      blank_lz = 1'($urandom_range(0, 1));
      startRun();
      for (int c = 0; c < 5 * 6 * (SD + 1); c++) begin
        @(posedge CP);
        checks++;
        if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
          failures++;
          $display("FAIL random r=%0d n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", r, n, an, seg, dp, expAn, expSeg, expDp);
        end
        if ($urandom_range(0, 2) == 0) begin
          setTime(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
          blank_lz = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) blink_sel = 2'($urandom_range(0, 3));
        end
        modelEdge();
      end
    end
  endtask

  task automatic test_hold_and_async();
    setTime(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd3);
    blank_lz = 1'b0;
    blink_sel = 2'd0;
    startRun();
    for (int c = 0; c < 42; c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL hold n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      if (n == 27) SecL = 4'd4;
      if (c < 41) modelEdge();
    end
    checks++;
    if (an === 6'b111111) begin
      failures++;
      $display("FAIL pre_async_show got an=%b exp a digit enabled", an);
    end
    #2 nCR = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {6'b111111, 7'b0000000, 1'b0}) begin
      failures++;
      $display("FAIL midshow_async got an=%b seg=%b dp=%b exp an=111111 seg=0000000 dp=0", an, seg, dp);
    end
    startRun();
    @(posedge CP);
    checks++;
    if (an !== 6'b111110) begin
      failures++;
      $display("FAIL restart_idx0 got an=%b exp an=111110", an);
    end
    modelEdge();
    for (int c = 0; c < 40; c++) begin
      @(posedge CP);
      checks++;
      if ({an, seg, dp} !== {expAn, expSeg, expDp}) begin
        failures++;
        $display("FAIL restart n=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b", n, an, seg, dp, expAn, expSeg, expDp);
      end
      modelEdge();
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_scan();
    test_dash();
    test_lz();
    test_blink();
    test_random();
    test_hold_and_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
